binary_add_pipe: RTL
====================

// Module: binary_add_pipe
// PURPOSE
//   Parametrised, pipelined two's-complement adder/subtractor; next generation of the 13-bit registered adder.
//   The carry chain is split into STAGES register-separated segments, so WIDTH scales without lengthening the critical path.
//   Valid/ready handshake on both sides replaces the plain enable; adds subtract, carry/borrow-in, carry-out and signed overflow.
//   Sits between operand producers and result consumers in the datapath.
// PARAMETERS
//   WIDTH   13  operand/result width in bits, >= 2
//   STAGES  2   pipeline depth = latency in cycles, 1..WIDTH; SEG = ceil(WIDTH/STAGES) bits per stage, last stage takes the remainder
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block accepts operands this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   op         in   1      0 = A+B+cin, 1 = A-B-cin (cin acts as borrow-in)
//   cin        in   1      carry-in / borrow-in
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      raw carry out of MSB (sub: 1 = no borrow)
//   ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset (async assert, sync release): all stage valid bits, out_valid, sum, cout, ovf = 0; in_ready = 1 after reset.
//   - Effective operands: b_eff = op ? ~b : b; c_eff = op ? ~cin : cin. Result = a + b_eff + c_eff.
//   - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//   - Global advance: adv = !out_valid | out_ready; in_ready = adv. All stages shift together on adv.
//   - Stage k (0-based) adds bits [k*SEG +: SEG] with the carry registered from stage k-1 (stage 0 uses c_eff).
//     Unprocessed upper operand bits and completed lower sum bits travel with the token in pipeline registers.
//   - Latency exactly STAGES cycles from accept to out_valid when out_ready is held high; throughput 1 per cycle.
//   - Bubbles are not collapsed: an invalid slot advances like a valid one; sum/cout/ovf of invalid slots are don't-care internally.
//   - Stall: out_valid & !out_ready -> every register holds; sum/cout/ovf/out_valid stable until accepted; in_ready = 0.
//   - Simultaneous accept and emit in one cycle is legal and loses no data.
//   - ovf is computed in the final stage only, from the carries into and out of bit WIDTH-1.
//   - Reset mid-operation discards every in-flight token; no partial result is ever emitted.
//   - STAGES = 1: single registered adder, latency 1. STAGES = WIDTH: one bit per stage.
// STRUCTURE
//   - Package binary_add_pkg: OP_ADD = 1'b0, OP_SUB = 1'b1; function seg_width(WIDTH, STAGES).
//   - Sub-module add_seg #(W): combinational W-bit ripple adder (a, b, cin -> s, cout, c_msb_in).
//     Built from the existing FA cell; instantiated once per stage through a generate loop.
//   - Top level contains only the pipeline registers, valid bits and handshake logic.
// TESTING
//   - WIDTH=13, STAGES=2, op=0: a=4095, b=1, cin=0 -> sum=4096, cout=0, ovf=1; out_valid exactly 2 cycles after accept.
//   - op=0: a=8191, b=1, cin=0 -> sum=0, cout=1, ovf=0. a=8191, b=0, cin=1 -> sum=0, cout=1.
//   - op=1: a=0, b=1, cin=0 -> sum=8191, cout=0, ovf=0. a=4096, b=1 -> sum=4095, cout=1, ovf=1.
//   - Back-to-back stream of 8 ops, out_ready low for 3 cycles mid-stream:
//     -> in_ready low during the stall, outputs held, all 8 results in order with none lost or duplicated.
//   - Assert rst_n with 2 tokens in flight -> out_valid=0 next edge; no stale result after release.
//   - Builds with STAGES=1, STAGES=5 (uneven split) and STAGES=13:
//     -> 10k random ops with random out_ready match the reference model a + b_eff + c_eff.

Source files
------------

// File: rtl/binary_add_pkg.sv
// ---------------------------------------------------------------------------
// binary_add_pkg
//   Shared constants and helpers for the pipelined adder/subtractor.
//   OP_ADD / OP_SUB : encodings of the op input.
//   seg_width()     : bits handled per pipeline stage, ceil(width / stages).
// ---------------------------------------------------------------------------
package binary_add_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int seg_width(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/binary_add_pipe_add_seg.sv
// ---------------------------------------------------------------------------
// fa_cell : one-bit full adder.
//   a_i, b_i, ci_i -> s_o (sum), co_o (carry out)
//
// add_seg #(W) : combinational W-bit ripple adder built from fa_cell.
//   a_i, b_i [W-1:0], cin_i -> s_o [W-1:0], cout_o (carry out of bit W-1),
//   c_msb_in_o (carry into bit W-1, used for signed overflow).
// ---------------------------------------------------------------------------
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module add_seg #(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o,
  output logic         c_msb_in_o
);
  logic [W:0] carry;

  assign carry[0] = cin_i;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    fa_cell u_fa (
      .a_i (a_i[gi]),
      .b_i (b_i[gi]),
      .ci_i(carry[gi]),
      .s_o (s_o[gi]),
      .co_o(carry[gi+1])
    );
  end

  assign cout_o     = carry[W];
  assign c_msb_in_o = carry[W-1];
endmodule

// File: rtl/binary_add_pipe.sv
// ---------------------------------------------------------------------------
// binary_add_pipe
//   Pipelined two's-complement adder/subtractor with valid/ready handshake.
//   The carry chain is cut into STAGES segments of seg_width() bits; each
//   stage adds its slice and forwards the carry plus the remaining operand
//   bits and the finished low sum bits to the next stage.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   operand handshake
//     a, b [WIDTH]          operands
//     op                    OP_ADD: a+b+cin, OP_SUB: a-b-cin
//     cin                   carry-in / borrow-in
//     out_valid / out_ready result handshake
//     sum [WIDTH]           result modulo 2^WIDTH
//     cout                  raw carry out of the MSB (sub: 1 = no borrow)
//     ovf                   signed overflow
// ---------------------------------------------------------------------------
module binary_add_pipe
  import binary_add_pkg::*;
#(
  parameter int WIDTH  = 13,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  // Whole pipeline moves as one; a stalled output freezes everything.
  logic adv;

  // Per-stage register outputs, indexed by stage.
  logic             st_v [STAGES];
  logic             st_c [STAGES];
  logic             st_m [STAGES];   // carry into bit WIDTH-1, once known
  logic [WIDTH-1:0] st_s [STAGES];
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];

  // Subtraction folds into addition: a + ~b + ~borrow.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign c_eff = (op == OP_SUB) ? ~cin : cin;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * SEG;
    localparam int HI = (LO + SEG > WIDTH) ? WIDTH : LO + SEG;
    localparam int SW = (HI > LO) ? HI - LO : 0;

    logic             v_in;
    logic             c_in;
    logic             m_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;

    logic             c_d;
    logic             m_d;
    logic [WIDTH-1:0] s_d;

    logic             v_q;
    logic             c_q;
    logic             m_q;
    logic [WIDTH-1:0] s_q;

    // Operand bits below LO are already consumed; only the slice is used.
    logic unused_bits;
    assign unused_bits = ^{a_in, b_in};

    if (gi == 0) begin : g_src_in
      assign v_in = in_valid;
      assign c_in = c_eff;
      assign m_in = 1'b0;
      assign a_in = a;
      assign b_in = b_eff;
      assign s_in = '0;
    end else begin : g_src_prev
      assign v_in = st_v[gi-1];
      assign c_in = st_c[gi-1];
      assign m_in = st_m[gi-1];
      assign a_in = st_a[gi-1];
      assign b_in = st_b[gi-1];
      assign s_in = st_s[gi-1];
    end

    if (SW > 0) begin : g_add
      logic [SW-1:0] seg_s;
      logic          seg_c;
      logic          seg_m;

      add_seg #(.W(SW)) u_seg (
        .a_i       (a_in[LO +: SW]),
        .b_i       (b_in[LO +: SW]),
        .cin_i     (c_in),
        .s_o       (seg_s),
        .cout_o    (seg_c),
        .c_msb_in_o(seg_m)
      );

      always_comb begin
        s_d           = s_in;
        s_d[LO +: SW] = seg_s;
      end
      assign c_d = seg_c;
      // Only the segment holding the MSB knows the carry into it.
      assign m_d = (HI == WIDTH) ? seg_m : m_in;
    end else begin : g_pass
      // Trailing stage with no bits left when SEG*STAGES overshoots WIDTH.
      assign s_d = s_in;
      assign c_d = c_in;
      assign m_d = m_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        m_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= c_d;
        m_q <= m_d;
        s_q <= s_d;
      end
    end

    assign st_v[gi] = v_q;
    assign st_c[gi] = c_q;
    assign st_m[gi] = m_q;
    assign st_s[gi] = s_q;

    // Operands only need to travel to stages that still have work to do.
    if (gi < STAGES - 1) begin : g_opnd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in;
          b_q <= b_in;
        end
      end

      assign st_a[gi] = a_q;
      assign st_b[gi] = b_q;
    end else begin : g_no_opnd
      assign st_a[gi] = '0;
      assign st_b[gi] = '0;
    end
  end

  logic unused_tail;
  assign unused_tail = ^{st_a[STAGES-1], st_b[STAGES-1]};

  assign out_valid = st_v[STAGES-1];
  assign sum       = st_s[STAGES-1];
  assign cout      = st_c[STAGES-1];
  assign ovf       = st_c[STAGES-1] ^ st_m[STAGES-1];

endmodule
